data_mem_ctrl: RTL and testbench

- Data-memory slave for the single-cycle core, directly downstream of the core's memory-stage bus.
- Consumes the core's request, we_re, mask, address and store data; returns load data and a valid strobe.
- Holds an internal word-organised SRAM with byte-lane writes and a configurable number of wait states.
- Drives the core's data_mem_valid and load_data_in inputs.

---
 rtl/data_mem_ctrl.sv | 124 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory slave: word-organised SRAM with byte-lane writes,
// a programmable number of wait states and an out-of-range flag.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic        we_re,
    input  logic [3:0]  mask,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        valid,
    output logic        error
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT =
        4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [3:0]  lat_mask;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;

    logic [31:0] mem [DEPTH];

    logic                  access;
    logic                  acc_we;
    logic [3:0]            acc_mask;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_data;
    logic                  oor;
    logic [ADDR_WIDTH-1:0] idx;

    // Without wait states the access happens on the accepting edge,
    // so it must use the live inputs rather than the latches.
    always_comb begin
        access   = 1'b0;
        acc_we   = lat_we;
        acc_mask = lat_mask;
        acc_addr = lat_addr;
        acc_data = lat_data;
        if (WAIT_CYCLES == 0) begin
            access   = (state == IDLE) && request;
            acc_we   = we_re;
            acc_mask = mask;
            acc_addr = address;
            acc_data = store_data;
        end else begin
            access = (state == WAIT) && (cnt == 4'd0);
        end
        oor = |acc_addr[31:ADDR_WIDTH+2];
        idx = acc_addr[ADDR_WIDTH+1:2];
    end

    always_ff @(posedge clk) begin
        if (access && acc_we && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i]) begin
                    mem[idx][8*i +: 8] <= acc_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_mask  <= 4'd0;
            lat_addr  <= 32'd0;
            lat_data  <= 32'd0;
            load_data <= 32'd0;
            valid     <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (request) begin
                        lat_we   <= we_re;
                        lat_mask <= mask;
                        lat_addr <= address;
                        lat_data <= store_data;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (access) begin
                valid <= 1'b1;
                error <= oor;
                if (oor) begin
                    load_data <= 32'd0;
                end else if (!acc_we) begin
                    load_data <= mem[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with 1, 0 and 3 wait states.
// A vector table drives the main instance; hand sequences cover the rest.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic [2:0]  req;
    logic [2:0]  rstn;
    logic        we;
    logic [3:0]  msk;
    logic [31:0] adr;
    logic [31:0] sdat;
    logic [31:0] ld0, ld1, ld2;
    logic        v0, v1, v2;
    logic        e0, e1, e2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rstn[0]), .request(req[0]), .we_re(we),
        .mask(msk), .address(adr), .store_data(sdat),
        .load_data(ld0), .valid(v0), .error(e0)
    );

    data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rstn[1]), .request(req[1]), .we_re(we),
        .mask(msk), .address(adr), .store_data(sdat),
        .load_data(ld1), .valid(v1), .error(e1)
    );

    data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) dut_c (
        .clk(clk), .rst(rstn[2]), .request(req[2]), .we_re(we),
        .mask(msk), .address(adr), .store_data(sdat),
        .load_data(ld2), .valid(v2), .error(e2)
    );

    typedef struct {
        logic        we;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ld;
        logic        er;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic vld(input int d);
        case (d)
            0: return v0;
            1: return v1;
            default: return v2;
        endcase
    endfunction

    function automatic logic erf(input int d);
        case (d)
            0: return e0;
            1: return e1;
            default: return e2;
        endcase
    endfunction

    function automatic logic [31:0] ldf(input int d);
        case (d)
            0: return ld0;
            1: return ld1;
            default: return ld2;
        endcase
    endfunction

    // lat = edges after the accepting edge until valid is seen
    task automatic txn(input int d, input int lat, input logic w,
                       input logic [3:0] m, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] exp_ld,
                       input logic exp_er, input bit disturb,
                       input string name);
        int cyc;
        @(negedge clk);
        we = w; msk = m; adr = a; sdat = sd;
        req[d] = 1'b1;
        @(posedge clk);
        #1;
        req[d] = 1'b0;
        if (disturb) begin
            adr = adr ^ 32'h0C;
            sdat = ~sdat;
            we = ~we;
            msk = ~msk;
        end
        cyc = -1;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (vld(d)) begin
                cyc = c;
                break;
            end
        end
        chk({name, " latency"}, cyc, lat);
        chk({name, " load_data"}, ldf(d), exp_ld);
        chk({name, " error"}, {31'd0, erf(d)}, {31'd0, exp_er});
        @(posedge clk);
        #1;
        chk({name, " valid drop"}, {31'd0, vld(d)}, 32'd0);
    endtask

    initial begin
        int nv;
        int prev;
        vecs = '{
            '{1'b1, 4'hF, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0},
            '{1'b0, 4'hF, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0},
            '{1'b1, 4'hF, 32'h20,  32'h11223344, 32'hDEADBEEF, 1'b0},
            '{1'b1, 4'h2, 32'h20,  32'h0000AA00, 32'hDEADBEEF, 1'b0},
            '{1'b0, 4'h0, 32'h20,  32'h0,        32'h1122AA44, 1'b0},
            '{1'b1, 4'hF, 32'h0,   32'h12345678, 32'h1122AA44, 1'b0},
            '{1'b0, 4'hF, 32'h400, 32'h0,        32'h0,        1'b1},
            '{1'b1, 4'hF, 32'h400, 32'h0000FFFC, 32'h0,        1'b1},
            '{1'b0, 4'hF, 32'h0,   32'h0,        32'h12345678, 1'b0},
            '{1'b1, 4'h0, 32'h20,  32'hFFFFFFFF, 32'h12345678, 1'b0},
            '{1'b0, 4'hF, 32'h22,  32'h0,        32'h1122AA44, 1'b0},
            '{1'b1, 4'hF, 32'h3FC, 32'hCAFEF00D, 32'h1122AA44, 1'b0},
            '{1'b0, 4'hF, 32'h3FD, 32'h0,        32'hCAFEF00D, 1'b0}
        };

        req = 3'b000; rstn = 3'b000;
        we = 1'b0; msk = 4'h0; adr = 32'h0; sdat = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset v0", {31'd0, v0}, 32'd0);
        chk("reset e0", {31'd0, e0}, 32'd0);
        chk("reset ld0", ld0, 32'd0);
        chk("reset v1", {31'd0, v1}, 32'd0);
        chk("reset ld1", ld1, 32'd0);
        chk("reset v2", {31'd0, v2}, 32'd0);
        chk("reset ld2", ld2, 32'd0);
        rstn = 3'b111;

        for (int i = 0; i < 13; i++) begin
            txn(0, 1, vecs[i].we, vecs[i].m, vecs[i].a, vecs[i].d,
                vecs[i].ld, vecs[i].er, 1'b0, $sformatf("vec%0d", i));
        end

        // zero wait states, request held: accept every other cycle
        @(negedge clk);
        we = 1'b1; msk = 4'h0; adr = 32'h0; sdat = 32'hFFFFFFFF;
        req[1] = 1'b1;
        nv = 0;
        prev = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("held valid edge%0d", k), {31'd0, v1},
                {31'd0, k[0]});
            if (v1) begin
                nv++;
                chk($sformatf("held error edge%0d", k), {31'd0, e1}, 32'd0);
                chk("held back-to-back", prev, 0);
            end
            prev = int'(v1);
        end
        @(negedge clk);
        req[1] = 1'b0;
        chk("held valid count", nv, 3);
        chk("held ld1", ld1, 32'd0);

        // three wait states: reset while a store is still pending
        txn(2, 3, 1'b1, 4'hF, 32'h30, 32'h11111111, 32'h0, 1'b0, 1'b0, "c_init30");
        txn(2, 3, 1'b1, 4'hF, 32'h38, 32'h77777777, 32'h0, 1'b0, 1'b0, "c_init38");
        @(negedge clk);
        we = 1'b1; msk = 4'h1; adr = 32'h30; sdat = 32'h55;
        req[2] = 1'b1;
        @(posedge clk);
        #1;
        req[2] = 1'b0;
        @(negedge clk);
        rstn[2] = 1'b0;
        #1;
        chk("midreset valid", {31'd0, v2}, 32'd0);
        @(negedge clk);
        rstn[2] = 1'b1;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (v2) nv++;
        end
        chk("midreset no valid", nv, 0);
        txn(2, 3, 1'b0, 4'hF, 32'h30, 32'h0, 32'h11111111, 1'b0, 1'b0, "c_after_rst");

        // inputs disturbed after acceptance must not affect the access
        txn(2, 3, 1'b1, 4'hF, 32'h34, 32'hA1B2C3D4, 32'h11111111, 1'b0, 1'b1, "iso_store");
        txn(2, 3, 1'b0, 4'hF, 32'h34, 32'h0, 32'hA1B2C3D4, 1'b0, 1'b0, "iso_rd34");
        txn(2, 3, 1'b0, 4'hF, 32'h38, 32'h0, 32'h77777777, 1'b0, 1'b0, "iso_rd38");
        txn(2, 3, 1'b0, 4'hF, 32'h34, 32'h0, 32'hA1B2C3D4, 1'b0, 1'b1, "iso_load");
        txn(2, 3, 1'b0, 4'hF, 32'h34, 32'h0, 32'hA1B2C3D4, 1'b0, 1'b0, "iso_rd34b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
